// File: rtl/maze_input_pkg.sv
// Shared definitions for the maze game input front end: button FSM state
// encoding, direction codes and the counter sizing helper.
package maze_input_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } btn_state_e;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // One shared counter serves debounce and repeat timing, so it is sized
    // for the longest interval it must ever reach.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One direction button: two-flop synchroniser, debounce FSM and auto-repeat
// timer producing a debounced level and single-cycle press/repeat pulses.
module btn_debounce_fsm
    import maze_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync_meta_q;
    logic             sync_x_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sync_meta_q <= 1'b0;
            sync_x_q    <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
        end else begin
            sync_meta_q <= btn_raw;
            sync_x_q    <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
        end
    end

    // level and pulse are decoded from the registered state so the press
    // pulse lands on the last stable debounce cycle, not one cycle later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        level   = 1'b0;
        pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_x_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync_x_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    level   = 1'b1;
                    pulse   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                level = 1'b1;
                if (!sync_x_q) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    // first_q selects the long initial delay; later repeats use the period
                    if (cnt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
                        pulse   = 1'b1;
                        cnt_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DEB_REL: begin
                level = 1'b1;
                if (sync_x_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    first_d = 1'b0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/maze_input_ctrl.sv
// Maze game input front end: four debounced direction buttons feeding a
// registered priority arbiter (U > D > L > R) and a move counter.
module maze_input_ctrl
    import maze_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [7:0] press_count
);

    logic [3:0] btn_raw;
    logic       move_valid_q, move_valid_d;
    logic [1:0] move_dir_q, move_dir_d;
    logic [7:0] press_count_q, press_count_d;

    assign btn_raw = {BtnU, BtnD, BtnL, BtnR};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN)
        ) u_btn (
            .ClkPort (ClkPort),
            .Reset   (Reset),
            .btn_raw (btn_raw[i]),
            .level   (btn_level[i]),
            .pulse   (btn_pulse[i])
        );
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            move_valid_q  <= 1'b0;
            move_dir_q    <= DIR_UP;
            press_count_q <= '0;
        end else begin
            move_valid_q  <= move_valid_d;
            move_dir_q    <= move_dir_d;
            press_count_q <= press_count_d;
        end
    end

    // Losing pulses in a collision are dropped; move_dir holds its last value when idle.
    always_comb begin
        move_valid_d  = |btn_pulse;
        move_dir_d    = move_dir_q;
        press_count_d = press_count_q + (move_valid_q ? 8'd1 : 8'd0);
        if (btn_pulse[3])      move_dir_d = DIR_UP;
        else if (btn_pulse[2]) move_dir_d = DIR_DOWN;
        else if (btn_pulse[1]) move_dir_d = DIR_LEFT;
        else if (btn_pulse[0]) move_dir_d = DIR_RIGHT;
    end

    assign move_valid  = move_valid_q;
    assign move_dir    = move_dir_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_maze_input_ctrl.sv
// Self-checking bench for maze_input_ctrl with short debounce/repeat timing:
// a table of press scenarios plus directed cycle-exact corner cases.
module tb_maze_input_ctrl;

    logic       ClkPort;
    logic       Reset;
    logic       BtnU, BtnD, BtnL, BtnR;
    logic [3:0] btn_level, btn_pulse;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [7:0] press_count;
    logic [3:0] nr_level, nr_pulse;
    logic       nr_move_valid;
    logic [1:0] nr_move_dir;
    logic [7:0] nr_press_count;

    int tests_run  = 0;
    int fail_count = 0;
    int pulse_cnt[4];
    int move_cnt;
    int nr_pulse_total;
    logic [1:0] last_dir;

    typedef struct {
        logic [3:0] btns;
        int         hold;
        int         exp_u;
        int         exp_d;
        int         exp_l;
        int         exp_r;
        int         exp_moves;
        logic [1:0] exp_dir;
        int         exp_norep;
        int         exp_nr_moves;
    } vec_t;

    vec_t vecs[7];

    maze_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_EN       (1)
    ) u_dut (
        .ClkPort     (ClkPort),
        .Reset       (Reset),
        .BtnU        (BtnU),
        .BtnD        (BtnD),
        .BtnL        (BtnL),
        .BtnR        (BtnR),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .press_count (press_count)
    );

    maze_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_EN       (0)
    ) u_dut_norep (
        .ClkPort     (ClkPort),
        .Reset       (Reset),
        .BtnU        (BtnU),
        .BtnD        (BtnD),
        .BtnL        (BtnL),
        .BtnR        (BtnR),
        .btn_level   (nr_level),
        .btn_pulse   (nr_pulse),
        .move_valid  (nr_move_valid),
        .move_dir    (nr_move_dir),
        .press_count (nr_press_count)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    task automatic applyStimulus(input logic [3:0] btns);
        {BtnU, BtnD, BtnL, BtnR} = btns;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge ClkPort);
        #1;
        for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(btn_pulse[i]);
        nr_pulse_total += $countones(nr_pulse);
        if (move_valid) begin
            move_cnt++;
            last_dir = move_dir;
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        move_cnt       = 0;
        nr_pulse_total = 0;
        last_dir       = 2'd0;
    endtask

    initial begin
        logic [7:0] start_cnt, nr_start_cnt;
        int rep_list[6];

        clearCounts();
        applyStimulus(4'b0000);
        Reset = 1'b1;
        repeat (3) stepCycle();
        checkOutput("reset_level", 32'(btn_level), 32'd0);
        checkOutput("reset_pulse", 32'(btn_pulse), 32'd0);
        checkOutput("reset_move_valid", 32'(move_valid), 32'd0);
        checkOutput("reset_move_dir", 32'(move_dir), 32'd0);
        checkOutput("reset_press_count", 32'(press_count), 32'd0);
        Reset = 1'b0;
        repeat (2) stepCycle();

        // Clean press: U held 15 cycles, released after cycle 15
        start_cnt = press_count;
        applyStimulus(4'b1000);
        for (int c = 1; c <= 24; c++) begin
            stepCycle();
            if (c == 15) applyStimulus(4'b0000);
            if (c == 5) begin
                checkOutput("clean_pulse_c5", 32'(btn_pulse[3]), 32'd0);
                checkOutput("clean_level_c5", 32'(btn_level[3]), 32'd0);
            end
            if (c == 6) begin
                checkOutput("clean_pulse_c6", 32'(btn_pulse[3]), 32'd1);
                checkOutput("clean_level_c6", 32'(btn_level[3]), 32'd1);
            end
            if (c == 7) begin
                checkOutput("clean_pulse_c7", 32'(btn_pulse[3]), 32'd0);
                checkOutput("clean_move_valid_c7", 32'(move_valid), 32'd1);
                checkOutput("clean_move_dir_c7", 32'(move_dir), 32'd0);
            end
            if (c == 21) checkOutput("clean_level_c21", 32'(btn_level[3]), 32'd1);
            if (c == 22) checkOutput("clean_level_c22", 32'(btn_level[3]), 32'd0);
        end
        checkOutput("clean_count_delta", 32'(8'(press_count - start_cnt)), 32'd1);

        // btns, hold, U, D, L, R pulses, moves, dir, norep pulses, norep moves
        vecs[0] = '{4'b1000, 40, 3, 0, 0, 0, 3, 2'd0, 1, 1};
        vecs[1] = '{4'b0010,  3, 0, 0, 0, 0, 0, 2'd0, 0, 0};
        vecs[2] = '{4'b0001, 60, 0, 0, 0, 6, 6, 2'd3, 1, 1};
        vecs[3] = '{4'b0110, 10, 0, 1, 1, 0, 1, 2'd1, 2, 1};
        vecs[4] = '{4'b1001, 30, 2, 0, 0, 2, 2, 2'd0, 2, 1};
        vecs[5] = '{4'b0100,  5, 0, 1, 0, 0, 1, 2'd1, 1, 1};
        vecs[6] = '{4'b0001,  4, 0, 0, 0, 0, 0, 2'd0, 0, 0};

        for (int v = 0; v < 7; v++) begin
            clearCounts();
            start_cnt    = press_count;
            nr_start_cnt = nr_press_count;
            applyStimulus(vecs[v].btns);
            repeat (vecs[v].hold) stepCycle();
            applyStimulus(4'b0000);
            repeat (16) stepCycle();
            checkOutput($sformatf("vec%0d_pulses_u", v), 32'(pulse_cnt[3]), 32'(vecs[v].exp_u));
            checkOutput($sformatf("vec%0d_pulses_d", v), 32'(pulse_cnt[2]), 32'(vecs[v].exp_d));
            checkOutput($sformatf("vec%0d_pulses_l", v), 32'(pulse_cnt[1]), 32'(vecs[v].exp_l));
            checkOutput($sformatf("vec%0d_pulses_r", v), 32'(pulse_cnt[0]), 32'(vecs[v].exp_r));
            checkOutput($sformatf("vec%0d_moves", v), 32'(move_cnt), 32'(vecs[v].exp_moves));
            if (vecs[v].exp_moves > 0)
                checkOutput($sformatf("vec%0d_dir", v), 32'(last_dir), 32'(vecs[v].exp_dir));
            checkOutput($sformatf("vec%0d_count_delta", v),
                        32'(8'(press_count - start_cnt)), 32'(vecs[v].exp_moves));
            checkOutput($sformatf("vec%0d_level_idle", v), 32'(btn_level), 32'd0);
            checkOutput($sformatf("vec%0d_norep_pulses", v), 32'(nr_pulse_total),
                        32'(vecs[v].exp_norep));
            checkOutput($sformatf("vec%0d_norep_count_delta", v),
                        32'(8'(nr_press_count - nr_start_cnt)), 32'(vecs[v].exp_nr_moves));
            checkOutput($sformatf("vec%0d_norep_level_idle", v), 32'(nr_level), 32'd0);
        end

        // Auto-repeat: exact pulse cycles for R held 60 cycles
        rep_list = '{6, 26, 34, 42, 50, 58};
        clearCounts();
        applyStimulus(4'b0001);
        for (int c = 1; c <= 72; c++) begin
            logic exp_p;
            stepCycle();
            if (c == 60) applyStimulus(4'b0000);
            exp_p = 1'b0;
            foreach (rep_list[k]) if (rep_list[k] == c) exp_p = 1'b1;
            checkOutput($sformatf("repeat_pulse_c%0d", c), 32'(btn_pulse[0]), 32'(exp_p));
            if (c == 27) checkOutput("repeat_move_dir_c27", 32'(move_dir), 32'd3);
        end
        checkOutput("repeat_norep_pulses", 32'(nr_pulse_total), 32'd1);
        repeat (4) stepCycle();

        // Release bounce: 2-cycle low glitch while HELD
        applyStimulus(4'b1000);
        for (int c = 1; c <= 30; c++) begin
            stepCycle();
            if (c == 10) applyStimulus(4'b0000);
            if (c == 12) applyStimulus(4'b1000);
            if (c == 20) applyStimulus(4'b0000);
            if (c >= 7 && c <= 22)
                checkOutput($sformatf("bounce_no_pulse_c%0d", c), 32'(btn_pulse[3]), 32'd0);
            if (c >= 6 && c <= 26)
                checkOutput($sformatf("bounce_level_c%0d", c), 32'(btn_level[3]), 32'd1);
            if (c == 27) checkOutput("bounce_level_c27", 32'(btn_level[3]), 32'd0);
        end
        repeat (4) stepCycle();

        // Reset in the middle of debouncing a held U
        applyStimulus(4'b1000);
        repeat (4) stepCycle();
        Reset = 1'b1;
        #1;
        checkOutput("midrst_level", 32'(btn_level), 32'd0);
        checkOutput("midrst_pulse", 32'(btn_pulse), 32'd0);
        checkOutput("midrst_move_valid", 32'(move_valid), 32'd0);
        checkOutput("midrst_move_dir", 32'(move_dir), 32'd0);
        checkOutput("midrst_press_count", 32'(press_count), 32'd0);
        repeat (3) stepCycle();
        Reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            stepCycle();
            if (c == 5) checkOutput("midrst_pulse_c5", 32'(btn_pulse[3]), 32'd0);
            if (c == 6) checkOutput("midrst_pulse_c6", 32'(btn_pulse[3]), 32'd1);
        end
        applyStimulus(4'b0000);
        repeat (12) stepCycle();

        // Wrap: 256 clean presses from reset
        Reset = 1'b1;
        stepCycle();
        Reset = 1'b0;
        repeat (2) stepCycle();
        for (int n = 1; n <= 256; n++) begin
            applyStimulus(4'b1000);
            repeat (6) stepCycle();
            applyStimulus(4'b0000);
            repeat (10) stepCycle();
            if (n == 255) checkOutput("wrap_count_255", 32'(press_count), 32'd255);
        end
        checkOutput("wrap_count_0", 32'(press_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
